// File: rtl/piso_serializer_if.sv
// Handshake and serial-link bundle between a word source and piso_serializer.
// The word source drives data_in/valid/ce; the serializer drives the rest.
interface piso_serializer_if #(
  parameter int N = 6
);
  logic [N-1:0] data_in;
  logic         valid;
  logic         ready;
  logic         ce;
  logic         ser_out;
  logic         frame;
  logic         done;

  modport master (
    output data_in,
    output valid,
    output ce,
    input  ready,
    input  ser_out,
    input  frame,
    input  done
  );

  modport slave (
    input  data_in,
    input  valid,
    input  ce,
    output ready,
    output ser_out,
    output frame,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: takes an N-bit word on a valid/ready
// handshake and shifts it out one bit per ce tick, framed by frame and done.
module piso_serializer #(
  parameter int N         = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  piso_serializer_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [N-1:0]    shift_r;
  logic [N-1:0]    shift_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic            ser_r;
  logic            ser_s;
  logic            frame_r;
  logic            frame_s;
  logic            done_r;
  logic            done_s;
  logic            ready_s;
  logic            load_s;
  logic            step_s;
  logic            last_s;

  // Bit of a word that goes on the line first, given the shift direction.
  function automatic logic first_bit(input logic [N-1:0] w);
    if (MSB_FIRST) begin
      first_bit = w[N-1];
    end else begin
      first_bit = w[0];
    end
  endfunction

  // Word after one bit has been consumed from the transmit end.
  function automatic logic [N-1:0] shift_once(input logic [N-1:0] w);
    if (MSB_FIRST) begin
      shift_once = {w[N-2:0], 1'b0};
    end else begin
      shift_once = {1'b0, w[N-1:1]};
    end
  endfunction

  assign load_s = (state_r == IDLE) && bus.valid;
  assign step_s = (state_r == SHIFT) && bus.ce;
  assign last_s = (cnt_r == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; ce in IDLE and valid in SHIFT are ignored
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.valid) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bus.ce && last_s) begin
          state_s = IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath next values: load, advance one bit, or close the frame
  always_comb begin
    shift_s = shift_r;
    cnt_s   = cnt_r;
    ser_s   = ser_r;
    frame_s = frame_r;
    done_s  = 1'b0;
    if (load_s) begin
      // a ce on the load edge is not a bit tick, so the first bit gets a full period
      shift_s = bus.data_in;
      cnt_s   = {CW{1'b0}};
      ser_s   = first_bit(bus.data_in);
      frame_s = 1'b1;
    end else if (step_s && !last_s) begin
      shift_s = shift_once(shift_r);
      cnt_s   = cnt_r + CW'(1'b1);
      ser_s   = first_bit(shift_once(shift_r));
      frame_s = 1'b1;
    end else if (step_s) begin
      shift_s = {N{1'b0}};
      cnt_s   = {CW{1'b0}};
      ser_s   = 1'b0;
      frame_s = 1'b0;
      done_s  = 1'b1;
    end else begin
      shift_s = shift_r;
      cnt_s   = cnt_r;
      ser_s   = ser_r;
      frame_s = frame_r;
      done_s  = 1'b0;
    end
  end

  // Datapath and output registers; reset aborts any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
      ser_r   <= 1'b0;
      frame_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      ser_r   <= ser_s;
      frame_r <= frame_s;
      done_r  <= done_s;
    end
  end

  // Output decode: ready follows the state directly
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = 1'b1;
      SHIFT:   ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  assign bus.ready   = ready_s;
  assign bus.ser_out = ser_r;
  assign bus.frame   = frame_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// receive identical stimulus and are checked against hand-computed bit orders.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  piso_serializer_if #(.N(6)) bus_m ();
  piso_serializer_if #(.N(6)) bus_l ();

  piso_serializer #(.N(6), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m.slave)
  );

  piso_serializer #(.N(6), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_inputs(input logic [5:0] d, input logic v, input logic c);
    bus_m.data_in = d;
    bus_l.data_in = d;
    bus_m.valid   = v;
    bus_l.valid   = v;
    bus_m.ce      = c;
    bus_l.ce      = c;
  endtask

  task automatic set_ce(input logic c);
    bus_m.ce = c;
    bus_l.ce = c;
  endtask

  task automatic set_valid(input logic v);
    bus_m.valid = v;
    bus_l.valid = v;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready_m"}, 32'(bus_m.ready), 32'd1);
    check_eq({tag, "_frame_m"}, 32'(bus_m.frame), 32'd0);
    check_eq({tag, "_ser_m"},   32'(bus_m.ser_out), 32'd0);
    check_eq({tag, "_done_m"},  32'(bus_m.done), 32'd0);
    check_eq({tag, "_ready_l"}, 32'(bus_l.ready), 32'd1);
    check_eq({tag, "_frame_l"}, 32'(bus_l.frame), 32'd0);
    check_eq({tag, "_ser_l"},   32'(bus_l.ser_out), 32'd0);
    check_eq({tag, "_done_l"},  32'(bus_l.done), 32'd0);
  endtask

  // Present a word for one edge; exp_* hold the send order, first bit at [5].
  task automatic load_word(input string tag, input logic [5:0] w, input logic [5:0] exp_m,
                           input logic [5:0] exp_l, input logic ce_on_load, input bit hold_valid);
    @(negedge clk);
    set_inputs(w, 1'b1, ce_on_load);
    @(posedge clk);
    #1;
    if (!hold_valid) set_valid(1'b0);
    set_ce(1'b0);
    check_eq({tag, "_ld_frame"}, 32'({bus_m.frame, bus_l.frame}), 32'b11);
    check_eq({tag, "_ld_ready"}, 32'({bus_m.ready, bus_l.ready}), 32'b00);
    check_eq({tag, "_ld_done"},  32'({bus_m.done, bus_l.done}), 32'b00);
    check_eq({tag, "_ld_ser_m"}, 32'(bus_m.ser_out), 32'(exp_m[5]));
    check_eq({tag, "_ld_ser_l"}, 32'(bus_l.ser_out), 32'(exp_l[5]));
  endtask

  // Run up to max_cycles clocks with ce every period clocks, checking each cycle.
  task automatic shift_word(input string tag, input logic [5:0] exp_m, input logic [5:0] exp_l,
                            input int period, input int max_cycles, input bit disturb);
    int idx;
    for (int k = 1; k <= max_cycles; k++) begin
      @(negedge clk);
      set_ce((k % period) == 0);
      if (disturb) begin
        bus_m.data_in = 6'($urandom_range(0, 63));
        bus_l.data_in = bus_m.data_in;
        set_valid(k[0]);
      end
      @(posedge clk);
      #1;
      if (k < 6 * period) begin
        idx = 5 - (k / period);
        check_eq({tag, "_ser_m"}, 32'(bus_m.ser_out), 32'(exp_m[idx]));
        check_eq({tag, "_ser_l"}, 32'(bus_l.ser_out), 32'(exp_l[idx]));
        check_eq({tag, "_frame"}, 32'({bus_m.frame, bus_l.frame}), 32'b11);
        check_eq({tag, "_done"},  32'({bus_m.done, bus_l.done}), 32'b00);
      end else begin
        check_eq({tag, "_end_frame"}, 32'({bus_m.frame, bus_l.frame}), 32'b00);
        check_eq({tag, "_end_ser"},   32'({bus_m.ser_out, bus_l.ser_out}), 32'b00);
        check_eq({tag, "_end_done"},  32'({bus_m.done, bus_l.done}), 32'b11);
        check_eq({tag, "_end_ready"}, 32'({bus_m.ready, bus_l.ready}), 32'b11);
      end
    end
    set_ce(1'b0);
    if (disturb) set_valid(1'b0);
  endtask

  // One quiet clock after a frame: done must be a single-cycle pulse.
  task automatic idle_cycle(input string tag);
    @(negedge clk);
    set_ce(1'b1);
    @(posedge clk);
    #1;
    set_ce(1'b0);
    check_idle(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    set_inputs(6'd0, 1'b0, 1'b0);

    // 1: asynchronous reset mid-clock with random inputs
    repeat (2) begin
      @(negedge clk);
      set_inputs(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    set_inputs(6'($urandom_range(0, 63)), 1'b1, 1'b1);
    #1;
    check_idle("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst_held");
    @(negedge clk);
    set_inputs(6'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("rst_release");

    // 2: 6'b101100, ce every 4 clocks
    load_word("w2c", 6'b101100, 6'b101100, 6'b001101, 1'b0, 1'b0);
    shift_word("w2c", 6'b101100, 6'b001101, 4, 24, 1'b0);
    idle_cycle("w2c_after");

    // 3: 6'b000011, ce every 2 clocks; LSB-first sends 1,1,0,0,0,0
    load_word("w03", 6'b000011, 6'b000011, 6'b110000, 1'b0, 1'b0);
    shift_word("w03", 6'b000011, 6'b110000, 2, 12, 1'b0);
    idle_cycle("w03_after");

    // 4: back-to-back 6'h2A then 6'h15 with valid held high
    load_word("w2a", 6'h2A, 6'b101010, 6'b010101, 1'b0, 1'b1);
    bus_m.data_in = 6'h15;
    bus_l.data_in = 6'h15;
    shift_word("w2a", 6'b101010, 6'b010101, 4, 24, 1'b0);
    load_word("w15", 6'h15, 6'b010101, 6'b101010, 1'b0, 1'b0);
    shift_word("w15", 6'b010101, 6'b101010, 4, 24, 1'b0);
    idle_cycle("w15_after");

    // 5: ce on the load edge, data_in and valid disturbed during the frame
    load_word("w32", 6'b110010, 6'b110010, 6'b010011, 1'b1, 1'b0);
    shift_word("w32", 6'b110010, 6'b010011, 3, 18, 1'b1);
    idle_cycle("w32_after");

    // 6: reset after the third bit of 6'h3F, then 6'h01
    load_word("w3f", 6'h3F, 6'b111111, 6'b111111, 1'b0, 1'b0);
    shift_word("w3f", 6'b111111, 6'b111111, 4, 11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("abort_async");
    @(posedge clk);
    #1;
    check_idle("abort_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("abort_release");
    load_word("w01", 6'h01, 6'b000001, 6'b100000, 1'b0, 1'b0);
    shift_word("w01", 6'b000001, 6'b100000, 4, 24, 1'b0);
    idle_cycle("w01_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
